vector_sequencer: RTL and testbench

- Command initiator for the vector processor datapath: accepts queued vector instructions through a valid/ready handshake.
- Drives the processor control pins (address, op_enable, op, we, select_register) with fixed, parameterized hold timing.
- Reports completion of each instruction.
- Sits between the host/test controller and the vector processor, replacing hand-driven control stimulus.

---
 rtl/vector_sequencer.sv | 134 +++++++++++++
 tb/tb_vector_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_sequencer.sv
// Queued command initiator for the vector processor: pops instructions in FIFO order
// and drives the processor control pins for a fixed hold time, followed by a one-cycle gap.
module vector_sequencer #(
  parameter int DEPTH      = 4,
  parameter int MEM_CYCLES = 2,
  parameter int ALU_CYCLES = 1,
  parameter int ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [ADDR_W+2:0] instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] proc_address,
  output logic              proc_we,
  output logic              proc_op_enable,
  output logic              proc_op,
  output logic              proc_select_register,
  output logic              busy,
  output logic              done,
  output logic [15:0]       retired_count
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int INSTR_W  = ADDR_W + 3;
  localparam int MAX_HOLD = (MEM_CYCLES > ALU_CYCLES) ? MEM_CYCLES : ALU_CYCLES;
  localparam int CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, GAP} state_t;

  logic [INSTR_W-1:0] queue_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [PTR_W:0]     count_next;
  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;

  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] head;
  logic [1:0]         head_opc;
  logic               head_sel;
  logic [ADDR_W-1:0]  head_addr;
  logic [CNT_W-1:0]   head_hold;

  // Ready depends on occupancy alone, so a full queue never accepts even when popping.
  assign instr_ready = (count != FULL_COUNT);
  assign push        = instr_valid & instr_ready;
  assign pop         = ((state == IDLE) || (state == GAP)) && (count != '0);

  assign head      = queue_mem[rd_ptr];
  assign head_opc  = head[INSTR_W-1 -: 2];
  assign head_sel  = head[ADDR_W];
  assign head_addr = head[ADDR_W-1:0];
  assign head_hold = head_opc[1] ? CNT_W'(ALU_CYCLES - 1) : CNT_W'(MEM_CYCLES - 1);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage carries no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[wr_ptr] <= instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      count                <= '0;
      hold_cnt             <= '0;
      proc_address         <= '0;
      proc_we              <= 1'b0;
      proc_op_enable       <= 1'b0;
      proc_op              <= 1'b0;
      proc_select_register <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      retired_count        <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
      done  <= 1'b0;
      busy  <= (count_next != '0) || (state == EXEC) || pop;

      case (state)
        IDLE, GAP: begin
          if (pop) begin
            proc_we              <= (head_opc == 2'b01);
            proc_op_enable       <= head_opc[1];
            proc_op              <= (head_opc == 2'b11);
            proc_address         <= head_opc[1] ? '0 : head_addr;
            proc_select_register <= head_opc[1] ? 1'b0 : head_sel;
            hold_cnt             <= head_hold;
            state                <= EXEC;
          end else begin
            state <= IDLE;
          end
        end
        EXEC: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else begin
            proc_we              <= 1'b0;
            proc_op_enable       <= 1'b0;
            proc_op              <= 1'b0;
            proc_address         <= '0;
            proc_select_register <= 1'b0;
            done                 <= 1'b1;
            retired_count        <= retired_count + 16'd1;
            state                <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: per-opcode timing table plus queue-full,
// back-to-back and mid-instruction reset sequences.
module tb_vector_sequencer;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              instr_valid = 1'b0;
  logic [ADDR_W+2:0] instr = '0;
  logic              instr_ready;
  logic [ADDR_W-1:0] proc_address;
  logic              proc_we;
  logic              proc_op_enable;
  logic              proc_op;
  logic              proc_select_register;
  logic              busy;
  logic              done;
  logic [15:0]       retired_count;

  vector_sequencer #(
    .DEPTH(4), .MEM_CYCLES(2), .ALU_CYCLES(1), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_ready(instr_ready),
    .proc_address(proc_address),
    .proc_we(proc_we),
    .proc_op_enable(proc_op_enable),
    .proc_op(proc_op),
    .proc_select_register(proc_select_register),
    .busy(busy),
    .done(done),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] opc;
    logic       sel;
    logic [8:0] addr;
    logic       we;
    logic       en;
    logic       op;
    logic       esel;
    logic [8:0] eaddr;
    int         hold;
  } vec_t;

  vec_t vecs [6];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W+2:0] mk(input logic [1:0] opc, input logic sel, input logic [8:0] a);
    return {opc, sel, a};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_we"},   {31'd0, proc_we}, 32'd0);
    check({tag, "_en"},   {31'd0, proc_op_enable}, 32'd0);
    check({tag, "_op"},   {31'd0, proc_op}, 32'd0);
    check({tag, "_sel"},  {31'd0, proc_select_register}, 32'd0);
    check({tag, "_addr"}, {23'd0, proc_address}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         idx;
    int         dones;
    int         cyc;
    logic       will_push;
    logic       ready_low;
    logic       prev_we;
    logic [8:0] starts [$];
    logic       bb_we   [6];
    logic [8:0] bb_addr [6];
    logic       bb_done [6];
    logic       bb_sel  [6];

    //          opc    sel   addr     we    en    op    esel  eaddr   hold
    vecs[0] = '{2'b01, 1'b1, 9'h1A5, 1'b1, 1'b0, 1'b0, 1'b1, 9'h1A5, 2};
    vecs[1] = '{2'b00, 1'b0, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0FF, 2};
    vecs[2] = '{2'b10, 1'b1, 9'h155, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1};
    vecs[3] = '{2'b11, 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1};
    vecs[4] = '{2'b00, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 2};
    vecs[5] = '{2'b01, 1'b0, 9'h003, 1'b1, 1'b0, 1'b0, 1'b0, 9'h003, 2};

    bb_we   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bb_addr = '{9'h003, 9'h003, 9'h000, 9'h003, 9'h003, 9'h000};
    bb_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bb_sel  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held for two edges
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    check("reset_busy",    {31'd0, busy}, 32'd0);
    check("reset_done",    {31'd0, done}, 32'd0);
    check("reset_retired", {16'd0, retired_count}, 32'd0);
    check("reset_ready",   {31'd0, instr_ready}, 32'd1);

    // Single instructions into an idle sequencer
    for (int i = 0; i < 6; i++) begin
      instr_valid = 1'b1;
      instr = mk(vecs[i].opc, vecs[i].sel, vecs[i].addr);
      tick();
      instr_valid = 1'b0;
      check($sformatf("v%0d_queued_busy", i), {31'd0, busy}, 32'd1);
      for (int c = 0; c < vecs[i].hold; c++) begin
        tick();
        check($sformatf("v%0d_c%0d_we", i, c),   {31'd0, proc_we}, {31'd0, vecs[i].we});
        check($sformatf("v%0d_c%0d_en", i, c),   {31'd0, proc_op_enable}, {31'd0, vecs[i].en});
        check($sformatf("v%0d_c%0d_op", i, c),   {31'd0, proc_op}, {31'd0, vecs[i].op});
        check($sformatf("v%0d_c%0d_sel", i, c),  {31'd0, proc_select_register}, {31'd0, vecs[i].esel});
        check($sformatf("v%0d_c%0d_addr", i, c), {23'd0, proc_address}, {23'd0, vecs[i].eaddr});
        check($sformatf("v%0d_c%0d_done", i, c), {31'd0, done}, 32'd0);
      end
      tick();
      check_idle($sformatf("v%0d_gap", i));
      check($sformatf("v%0d_gap_done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_retired", i), {16'd0, retired_count}, i + 1);
      tick();
      check($sformatf("v%0d_after_done", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_after_busy", i), {31'd0, busy}, 32'd0);
    end

    // Back-to-back LOAD then STORE to 0x003
    instr_valid = 1'b1;
    instr = mk(2'b00, 1'b0, 9'h003);
    tick();
    instr = mk(2'b01, 1'b1, 9'h003);
    tick();
    instr_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("bb%0d_we", k),   {31'd0, proc_we}, {31'd0, bb_we[k]});
      check($sformatf("bb%0d_addr", k), {23'd0, proc_address}, {23'd0, bb_addr[k]});
      check($sformatf("bb%0d_done", k), {31'd0, done}, {31'd0, bb_done[k]});
      check($sformatf("bb%0d_sel", k),  {31'd0, proc_select_register}, {31'd0, bb_sel[k]});
      check($sformatf("bb%0d_we_en", k), {31'd0, proc_we & proc_op_enable}, 32'd0);
      if (k < 5) tick();
    end
    check("bb_retired", {16'd0, retired_count}, 32'd8);

    // Queue fill and back-pressure: seven STOREs offered back-to-back
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idx = 0;
    dones = 0;
    cyc = 0;
    ready_low = 1'b0;
    prev_we = 1'b0;
    while ((dones < 7) && (cyc < 300)) begin
      will_push = 1'b0;
      if (idx < 7) begin
        instr_valid = 1'b1;
        instr = mk(2'b01, idx[0], 9'(16 + idx));
        will_push = instr_ready;
      end else begin
        instr_valid = 1'b0;
      end
      tick();
      cyc++;
      if (will_push) idx++;
      if (!instr_ready) ready_low = 1'b1;
      if (proc_we && !prev_we) starts.push_back(proc_address);
      prev_we = proc_we;
      if (done) dones++;
      if (proc_we && proc_op_enable) check("fill_we_en", 32'd1, 32'd0);
    end
    instr_valid = 1'b0;
    check("fill_dones", dones, 32'd7);
    check("fill_pushed", idx, 32'd7);
    check("fill_ready_dropped", {31'd0, ready_low}, 32'd1);
    check("fill_starts", starts.size(), 32'd7);
    for (int k = 0; k < starts.size(); k++) begin
      check($sformatf("fill_order%0d", k), {23'd0, starts[k]}, 32'(16 + k));
    end
    check("fill_retired", {16'd0, retired_count}, 32'd7);
    tick();
    check("fill_idle_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a STORE with three instructions queued
    for (int k = 0; k < 5; k++) begin
      instr_valid = 1'b1;
      instr = mk(2'b01, 1'b1, 9'(32 + k));
      tick();
    end
    instr_valid = 1'b0;
    check("mid_pre_we",    {31'd0, proc_we}, 32'd1);
    check("mid_pre_addr",  {23'd0, proc_address}, 32'h21);
    check("mid_pre_busy",  {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_rst");
    check("mid_rst_busy",    {31'd0, busy}, 32'd0);
    check("mid_rst_done",    {31'd0, done}, 32'd0);
    check("mid_rst_retired", {16'd0, retired_count}, 32'd0);
    check("mid_rst_ready",   {31'd0, instr_ready}, 32'd1);
    for (int k = 0; k < 4; k++) tick();
    check("mid_drained_busy", {31'd0, busy}, 32'd0);
    check("mid_drained_we",   {31'd0, proc_we}, 32'd0);
    instr_valid = 1'b1;
    instr = mk(2'b01, 1'b0, 9'h0AA);
    tick();
    instr_valid = 1'b0;
    tick();
    check("mid_new_we",   {31'd0, proc_we}, 32'd1);
    check("mid_new_addr", {23'd0, proc_address}, 32'h0AA);
    tick();
    tick();
    check("mid_new_done",    {31'd0, done}, 32'd1);
    check("mid_new_retired", {16'd0, retired_count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
